// File: rtl/reg_write_controller_pkg.sv
// Shared register-interface definitions used by the write- and read-side stream controllers.
package reg_write_controller_pkg;

    localparam int BYTE_WIDTH = 8;
    localparam int ADDR_WIDTH = 8;

    localparam logic [BYTE_WIDTH-1:0] SYNC_BYTE_DEFAULT = 8'h55;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GET_ADDRESS = 2'd1,
        GET_DATA    = 2'd2,
        WRITE       = 2'd3
    } reg_state_t;

endpackage

// File: rtl/reg_write_controller_gap_timer.sv
// Saturating idle-gap counter: expired is high in the TIMEOUT-th consecutive enabled cycle.
module gap_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic ipClk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge ipClk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // count holds the idle cycles already seen, so the current idle cycle is the last allowed one.
    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/reg_write_controller.sv
// Parses sync/address/data byte packets from a valid/ready stream into single-cycle register writes.
// Handshake: a byte transfers on a rising ipClk edge where ipRxValid and opRxReady are both high.
module reg_write_controller
    import reg_write_controller_pkg::*;
#(
    parameter int                    DATA_LENGTH   = 4,
    parameter logic [BYTE_WIDTH-1:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
    parameter int                    NUM_REGISTERS = 16,
    parameter int                    TIMEOUT       = 1000
) (
    input  logic                              ipClk,
    input  logic                              reset,
    input  logic [BYTE_WIDTH-1:0]             ipRxData,
    input  logic                              ipRxValid,
    output logic                              opRxReady,
    output logic [ADDR_WIDTH-1:0]             opWrAddress,
    output logic [BYTE_WIDTH*DATA_LENGTH-1:0] opWrData,
    output logic                              opWrEnable,
    output logic                              opError,
    output logic                              opBusy,
    output reg_state_t                        debug_state
);

    localparam int DW    = BYTE_WIDTH * DATA_LENGTH;
    localparam int CNT_W = $clog2(DATA_LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(DATA_LENGTH - 1);

    reg_state_t             state;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DW-1:0]          data_q;
    logic [DW-1:0]          next_data;
    logic [CNT_W-1:0]       byte_cnt;
    logic                   accept;
    logic                   in_packet;
    logic                   addr_valid;
    logic                   expired;

    assign accept      = ipRxValid && opRxReady;
    assign in_packet   = (state == GET_ADDRESS) || (state == GET_DATA);
    assign addr_valid  = ({{(32-ADDR_WIDTH){1'b0}}, addr_q} < 32'(NUM_REGISTERS));
    assign debug_state = state;

    // Little-endian insertion of the incoming byte at the current byte slot.
    always_comb begin
        next_data = data_q;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            if (byte_cnt == CNT_W'(i)) begin
                next_data[i*BYTE_WIDTH +: BYTE_WIDTH] = ipRxData;
            end
        end
    end

    gap_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_gap_timer (
        .ipClk  (ipClk),
        .reset  (reset),
        .clear  (accept || !in_packet),
        .enable (in_packet && !accept),
        .expired(expired)
    );

    always_ff @(posedge ipClk) begin
        if (reset) begin
            state       <= IDLE;
            opRxReady   <= 1'b0;
            opWrAddress <= '0;
            opWrData    <= '0;
            opWrEnable  <= 1'b0;
            opError     <= 1'b0;
            opBusy      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            byte_cnt    <= '0;
        end else begin
            opWrEnable <= 1'b0;
            opError    <= 1'b0;
            case (state)
                IDLE: begin
                    opRxReady <= 1'b1;
                    if (accept && (ipRxData == SYNC_BYTE)) begin
                        state  <= GET_ADDRESS;
                        opBusy <= 1'b1;
                    end
                end
                GET_ADDRESS: begin
                    if (accept) begin
                        addr_q   <= ipRxData;
                        byte_cnt <= '0;
                        state    <= GET_DATA;
                    end else if (expired) begin
                        state   <= IDLE;
                        opError <= 1'b1;
                        opBusy  <= 1'b0;
                    end
                end
                GET_DATA: begin
                    if (accept) begin
                        data_q   <= next_data;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            state     <= WRITE;
                            opRxReady <= 1'b0;
                            byte_cnt  <= '0;
                            if (addr_valid) begin
                                opWrEnable  <= 1'b1;
                                opWrAddress <= addr_q;
                                opWrData    <= next_data;
                            end else begin
                                opError <= 1'b1;
                            end
                        end
                    end else if (expired) begin
                        state   <= IDLE;
                        opError <= 1'b1;
                        opBusy  <= 1'b0;
                    end
                end
                WRITE: begin
                    state     <= IDLE;
                    opRxReady <= 1'b1;
                    opBusy    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_write_controller.md
REG_WRITE_CONTROLLER -- requirements
Module: reg_write_controller

Interface
REQ-001 Parameter DATA_LENGTH, default 4; number of data bytes per write packet.
REQ-002 Parameter SYNC_BYTE, default 8'h55; packet start marker.
REQ-003 Parameter NUM_REGISTERS, default 16; valid addresses are 0 to NUM_REGISTERS-1.
REQ-004 Parameter TIMEOUT, default 1000; maximum idle cycles allowed between bytes inside a packet.
REQ-005 Reset and clock SHALL be: reset reset, synchronous, active-high; clock ipClk.
REQ-006 ipClk  input  1  system clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 ipRxData  input  8  incoming stream byte.
REQ-009 ipRxValid  input  1  ipRxData valid.
REQ-010 opRxReady  output  1  block can accept a byte.
REQ-011 opWrAddress  output  8  register write address.
REQ-012 opWrData  output  8*DATA_LENGTH  register write data.
REQ-013 opWrEnable  output  1  single-cycle write strobe.
REQ-014 opError  output  1  single-cycle error pulse.
REQ-015 opBusy  output  1  packet in progress (state not IDLE).

Function
REQ-016 A byte SHALL be accepted only in a cycle where ipRxValid and opRxReady are both high.
REQ-017 The FSM SHALL have four states: IDLE, GET_ADDRESS, GET_DATA, WRITE.
REQ-018 IDLE: an accepted byte equal to SYNC_BYTE SHALL move the FSM to GET_ADDRESS; any other accepted byte is discarded and the FSM stays in IDLE.
REQ-019 GET_ADDRESS: the accepted byte SHALL be latched as the address, the byte counter cleared, and the FSM moved to GET_DATA.
REQ-020 GET_DATA: data SHALL be assembled little-endian (first byte to bits [7:0]); after DATA_LENGTH bytes the FSM SHALL move to WRITE.
REQ-021 WRITE: opRxReady SHALL be low, and the FSM SHALL return to IDLE the following cycle.
REQ-022 opRxReady SHALL be high in IDLE, GET_ADDRESS and GET_DATA.
REQ-023 On entering WRITE with address < NUM_REGISTERS, opWrEnable SHALL pulse high for exactly one cycle, one cycle after the final data byte is accepted.
REQ-024 opWrAddress and opWrData SHALL be stable while opWrEnable is high, and SHALL hold their values until the next write.
REQ-025 On entering WRITE with address >= NUM_REGISTERS, opWrEnable SHALL stay low and opError SHALL pulse for one cycle.
REQ-026 In GET_ADDRESS or GET_DATA, if TIMEOUT consecutive cycles pass with no accepted byte, the FSM SHALL return to IDLE, pulse opError, and discard the partial packet.
REQ-027 The gap counter SHALL clear on every accepted byte and SHALL saturate rather than wrap.
REQ-028 A SYNC_BYTE value received in GET_ADDRESS or GET_DATA SHALL be treated as ordinary payload, not as a resynchronisation.
REQ-029 Back-to-back packets SHALL be supported: the first byte of the next packet is accepted in the cycle after WRITE.
REQ-030 Throughput SHALL be DATA_LENGTH+3 cycles per packet minimum: sync + address + data bytes + one WRITE cycle.

Reset
REQ-031 On reset the FSM SHALL go to IDLE; opWrEnable=0, opError=0, opBusy=0, opRxReady=0 during reset, and 1 the cycle after.
REQ-032 On reset opWrAddress=0 and opWrData=0, and the byte and gap counters SHALL clear.
REQ-033 Reset asserted mid-packet SHALL abandon the packet with no opWrEnable and no opError pulse.

Structure
REQ-034 The state enum, the SYNC_BYTE default and the packet field widths SHALL live in the shared registers package, shared with the read-side controller.
REQ-035 The timeout counter SHALL be a sub-module, gap_timer, with clear, enable and expired ports.
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 Reset, then send 55,03,EF,BE,AD,DE -> one opWrEnable pulse with opWrAddress=0x03 and opWrData=0xDEADBEEF, one cycle after byte DE.
REQ-038 Send 12,55,01,11,22,33,44 -> leading 0x12 ignored; write address 0x01, data 0x44332211.
REQ-039 Send 55,20,00,00,00,00 (NUM_REGISTERS=16) -> no opWrEnable; opError pulses once.
REQ-040 Send 55,05,AA, then hold ipRxValid low for 1000 cycles -> opError pulse, FSM in IDLE, opBusy=0; a following valid packet writes correctly.
REQ-041 Send two packets back-to-back with ipRxValid held high -> two writes 7 cycles apart; opRxReady low only in the WRITE cycles.
REQ-042 Assert reset after 55,02,01 -> no opWrEnable, no opError; all outputs 0 during reset.
